// File: rtl/dsp_accum_pkg.sv
// Shared types and default widths for the dsp_accum frame accumulator.
package dsp_accum_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int PW_DEF   = 16;
  localparam int ACCW_DEF = 32;
  localparam int CNTW_DEF = 8;

endpackage

// File: rtl/dsp_accum_add.sv
// Combinational accumulator adder with carry out.
// Optional clamp to all-ones on carry when DSP_ACCUM_SAT_EN is defined.
module dsp_accum_add #(
  parameter int ACCW = 32
) (
  input  logic [ACCW-1:0] acc,
  input  logic [ACCW-1:0] beat,
  output logic [ACCW-1:0] sum,
  output logic            carry
);

  logic [ACCW:0] raw;

  assign raw   = {1'b0, acc} + {1'b0, beat};
  assign carry = raw[ACCW];

`ifdef DSP_ACCUM_SAT_EN
  // Once clamped, any nonzero beat carries again, so the sum stays pinned.
  function automatic logic [ACCW-1:0] sat_clamp(input logic [ACCW:0] r);
    return r[ACCW] ? {ACCW{1'b1}} : r[ACCW-1:0];
  endfunction

  assign sum = sat_clamp(raw);
`else
  assign sum = raw[ACCW-1:0];
`endif

endmodule

// File: rtl/dsp_accum.sv
// Frame accumulator: sums unsigned product beats up to in_last, then holds
// the total/count/overflow on a valid/ready output. Saturation: DSP_ACCUM_SAT_EN.
module dsp_accum
  import dsp_accum_pkg::*;
#(
  parameter int PW   = PW_DEF,
  parameter int ACCW = ACCW_DEF,
  parameter int CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PW-1:0]   in_p,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ACCW-1:0] out_acc,
  output logic [CNTW-1:0] out_cnt,
  output logic            out_ovf
);

  generate
    if (ACCW < PW) begin : g_width_chk
      $error("dsp_accum: ACCW must be >= PW");
    end
  endgenerate

  state_t          state;
  state_t          state_nxt;
  logic [ACCW-1:0] acc;
  logic [ACCW-1:0] beat;
  logic [ACCW-1:0] sum;
  logic            carry;
  logic [CNTW-1:0] cnt;
  logic            ovf;
  logic            accept;
  logic            release_hold;

  function automatic logic [CNTW-1:0] cnt_sat_inc(input logic [CNTW-1:0] c);
    return (c == {CNTW{1'b1}}) ? c : c + 1'b1;
  endfunction

  assign beat         = ACCW'(in_p);
  assign accept       = in_valid && in_ready;
  assign release_hold = (state == HOLD) && out_ready;

  dsp_accum_add #(
    .ACCW (ACCW)
  ) u_add (
    .acc   (acc),
    .beat  (beat),
    .sum   (sum),
    .carry (carry)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && in_last) state_nxt = HOLD;
      HOLD:    if (out_ready)         state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // Handshake outputs depend on state only, keeping out_ready off in_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACC:     in_ready  = 1'b1;
      HOLD:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Accumulate stage; cleared on reset and when the held result is consumed.
  always_ff @(posedge clk) begin
    if (rst || release_hold) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= sum;
      cnt <= cnt_sat_inc(cnt);
      ovf <= ovf | carry;
    end
  end

  assign out_acc = acc;
  assign out_cnt = cnt;
  assign out_ovf = ovf;

endmodule

// File: tb/tb_dsp_accum.sv
// Self-checking bench for dsp_accum: three instances (default, ACCW=16, CNTW=2)
// share one stimulus stream and are compared against a frame-level sum model.
module tb_dsp_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_p;
  logic        in_last;
  logic        out_ready;

  logic        rdy_a, vld_a, ovf_a;
  logic [31:0] acc_a;
  logic [7:0]  cnt_a;
  logic        rdy_w, vld_w, ovf_w;
  logic [15:0] acc_w;
  logic [7:0]  cnt_w;
  logic        rdy_c, vld_c, ovf_c;
  logic [31:0] acc_c;
  logic [1:0]  cnt_c;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] beats[64];
  int          nb;

  typedef struct {
    int              n;
    logic [5:0][15:0] b;
    logic [31:0]     acc;
    logic [7:0]      cnt;
    logic            ovf;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  dsp_accum #(.PW(16), .ACCW(32), .CNTW(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a), .in_p(in_p),
    .in_last(in_last), .out_valid(vld_a), .out_ready(out_ready),
    .out_acc(acc_a), .out_cnt(cnt_a), .out_ovf(ovf_a));

  dsp_accum #(.PW(16), .ACCW(16), .CNTW(8)) u_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w), .in_p(in_p),
    .in_last(in_last), .out_valid(vld_w), .out_ready(out_ready),
    .out_acc(acc_w), .out_cnt(cnt_w), .out_ovf(ovf_w));

  dsp_accum #(.PW(16), .ACCW(32), .CNTW(2)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c), .in_p(in_p),
    .in_last(in_last), .out_valid(vld_c), .out_ready(out_ready),
    .out_acc(acc_c), .out_cnt(cnt_c), .out_ovf(ovf_c));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame result from the accepted beats: true total, then wrap or clamp.
  function automatic void model(input int accw, input int cntw, output logic [63:0] acc,
                                output logic [63:0] cnt, output logic ovf);
    logic [63:0] total, amax, cmax;
    total = 64'd0;
    for (int i = 0; i < nb; i++) total += 64'(beats[i]);
    amax = (64'd1 << accw) - 64'd1;
    cmax = (64'd1 << cntw) - 64'd1;
    ovf  = total > amax;
`ifdef DSP_ACCUM_SAT_EN
    acc = ovf ? amax : total;
`else
    acc = total & amax;
`endif
    cnt = (64'(nb) > cmax) ? cmax : 64'(nb);
  endfunction

  task automatic check_results(input string tag);
    logic [63:0] ea, ec;
    logic        eo;
    check({tag, " out_valid"}, {61'd0, vld_a, vld_w, vld_c}, 64'h7);
    check({tag, " in_ready"},  {61'd0, rdy_a, rdy_w, rdy_c}, 64'h0);
    model(32, 8, ea, ec, eo);
    check({tag, " acc_a"}, 64'(acc_a), ea);
    check({tag, " cnt_a"}, 64'(cnt_a), ec);
    check({tag, " ovf_a"}, 64'(ovf_a), 64'(eo));
    model(16, 8, ea, ec, eo);
    check({tag, " acc_w"}, 64'(acc_w), ea);
    check({tag, " ovf_w"}, 64'(ovf_w), 64'(eo));
    model(32, 2, ea, ec, eo);
    check({tag, " cnt_c"}, 64'(cnt_c), ec);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " out_valid"}, {61'd0, vld_a, vld_w, vld_c}, 64'h0);
    check({tag, " in_ready"},  {61'd0, rdy_a, rdy_w, rdy_c}, 64'h7);
    check({tag, " acc"}, {acc_a, acc_w, acc_c[15:0]}, 64'd0);
    check({tag, " cnt/ovf"}, {51'd0, cnt_a, cnt_w[1:0], ovf_a, ovf_w, ovf_c}, 64'd0);
    check({tag, " acc_c hi"}, 64'(acc_c), 64'd0);
  endtask

  // Drives beats[0..nb-1], last on the final one, optionally with idle gaps.
  task automatic send_frame(input bit gaps);
    for (int i = 0; i < nb; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_p     = 16'($urandom);
        in_last  = 1'($urandom);
        @(posedge clk); #1;
      end
      check("beat in_ready", {63'd0, rdy_a & rdy_w & rdy_c}, 64'd1);
      check("beat out_valid", {63'd0, vld_a | vld_w | vld_c}, 64'd0);
      in_valid = 1'b1;
      in_p     = beats[i];
      in_last  = (i == nb - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Holds the result for k cycles under garbage input, then consumes it.
  task automatic finish_frame(input int k);
    check_results("hold entry");
    for (int j = 0; j < k; j++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_p      = 16'($urandom);
      in_last   = 1'($urandom);
      @(posedge clk); #1;
      check_results("hold stall");
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_p      = 16'($urandom);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_last   = 1'b0;
    check_idle("after consume");
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_p = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("reset");

    tbl[0] = '{3, {16'd0, 16'd0, 16'd0, 16'd7, 16'd5, 16'd3}, 32'd15, 8'd3, 1'b0};
    tbl[1] = '{1, {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF}, 32'd65535, 8'd1, 1'b0};
    tbl[2] = '{2, {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, 32'd0, 8'd2, 1'b0};
    tbl[3] = '{4, {16'd0, 16'd0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 32'h3FFFC, 8'd4, 1'b0};
    tbl[4] = '{6, {16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 32'd21, 8'd6, 1'b0};

    for (int t = 0; t < 5; t++) begin
      nb = tbl[t].n;
      for (int i = 0; i < nb; i++) beats[i] = tbl[t].b[i];
      send_frame(1'b0);
      check("tbl acc", 64'(acc_a), 64'(tbl[t].acc));
      check("tbl cnt", 64'(cnt_a), 64'(tbl[t].cnt));
      check("tbl ovf", 64'(ovf_a), 64'(tbl[t].ovf));
      finish_frame(t == 2 ? 4 : 0);
    end

    // 16-bit accumulator carry: wrap to 1, or clamp to all-ones.
    nb = 2; beats[0] = 16'hFFFF; beats[1] = 16'h0002;
    send_frame(1'b0);
`ifdef DSP_ACCUM_SAT_EN
    check("accw16 acc", 64'(acc_w), 64'hFFFF);
`else
    check("accw16 acc", 64'(acc_w), 64'h0001);
`endif
    check("accw16 ovf", 64'(ovf_w), 64'd1);
    finish_frame(1);

    // Counter saturation on the 2-bit instance.
    nb = 5;
    for (int i = 0; i < 5; i++) beats[i] = 16'd1;
    send_frame(1'b0);
    check("cntw2 cnt", 64'(cnt_c), 64'd3);
    check("cntw2 acc", 64'(acc_c), 64'd5);
    finish_frame(0);

    // Reset mid-frame discards the partial sum.
    in_valid = 1'b1; in_p = 16'd9; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_idle("rst midframe");
    nb = 1; beats[0] = 16'd4;
    send_frame(1'b0);
    check("post-rst acc", 64'(acc_a), 64'd4);
    check("post-rst cnt", 64'(cnt_a), 64'd1);
    finish_frame(0);

    // Reset while holding an unconsumed result.
    nb = 2; beats[0] = 16'd100; beats[1] = 16'd200;
    send_frame(1'b0);
    check_results("pre-rst hold");
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_idle("rst hold");

    // Random frames, some biased to large products to exercise carry.
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(1, 12);
      for (int i = 0; i < nb; i++)
        beats[i] = (f % 3 == 0) ? 16'($urandom_range(16'hC000, 16'hFFFF)) : 16'($urandom);
      if (f % 7 == 0) beats[0] = 16'd0;
      send_frame(1'b1);
      finish_frame($urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
